// File: rtl/echo_pipeline_sequencer_pkg.sv
// Shared types and default timing for the echo pipeline sequencer.
// Visible to the sequencer, its wait timer and the testbench.
package echo_pipeline_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONV_EN   = 3'd1,
        ST_CONV_WAIT = 3'd2,
        ST_LAG_EN    = 3'd3,
        ST_LAG_WAIT  = 3'd4,
        ST_S3_EN     = 3'd5,
        ST_S3_WAIT   = 3'd6,
        ST_EMIT      = 3'd7
    } seq_state_e;

    localparam int DEF_PULSE_CYCLES  = 2;
    localparam int DEF_MIN_WAIT_CONV = 8;
    localparam int DEF_MIN_WAIT_LAG  = 600;
    localparam int DEF_MIN_WAIT_S3   = 1250;
    localparam int DEF_TIMEOUT       = 2048;

    // Width of the wait/pulse counters; wide enough for any 16-bit constant.
    localparam int TMR_W = 16;

    function automatic logic is_en_state(input seq_state_e s);
        return (s == ST_CONV_EN) || (s == ST_LAG_EN) || (s == ST_S3_EN);
    endfunction

    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_CONV_WAIT) || (s == ST_LAG_WAIT) || (s == ST_S3_WAIT);
    endfunction

endpackage

// File: rtl/echo_pipeline_sequencer_timer.sv
// Shared wait timer: counts clocks since load, flags end of the
// minimum wait and expiry of the ready timeout that follows it.
module stage_wait_timer
    import echo_pipeline_sequencer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [TMR_W-1:0] min_wait_i,
    input  logic [TMR_W-1:0] timeout_i,
    output logic             min_done_o,
    output logic             timed_out_o
);

    // cnt_q equals the number of clock edges since the load edge,
    // so the first edge where cnt_q == min is the first ready sample.
    logic [TMR_W:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0] min_q;
    logic [TMR_W-1:0] tmo_q;
    logic [TMR_W:0]   limit;

    assign limit = {1'b0, min_q} + {1'b0, tmo_q};

    // Next count: restart on load, saturating increment while running.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (TMR_W+1)'(1);
        end else if (run_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + (TMR_W+1)'(1);
        end
    end

    // Counter and latched limits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            min_q <= '0;
            tmo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load_i) begin
                min_q <= min_wait_i;
                tmo_q <= timeout_i;
            end
        end
    end

    assign min_done_o  = (cnt_q >= {1'b0, min_q});
    assign timed_out_o = (cnt_q >= limit);

endmodule

// File: rtl/echo_pipeline_sequencer.sv
// Frame sequencer for the echo pipeline: conv -> lag -> approx/cancel,
// then forwards the selected double result with a one-cycle strobe.
module echo_pipeline_sequencer
    import echo_pipeline_sequencer_pkg::*;
#(
    parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int MIN_WAIT_CONV = DEF_MIN_WAIT_CONV,
    parameter int MIN_WAIT_LAG  = DEF_MIN_WAIT_LAG,
    parameter int MIN_WAIT_S3   = DEF_MIN_WAIT_S3,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic [12:0] sampling_cycle_counter,
    input  logic        enable_para_approx,
    input  logic        ready_conv,
    input  logic        ready_lag,
    input  logic        ready_approx,
    input  logic        ready_cancel,
    input  logic [63:0] e,
    input  logic [63:0] signal_without_echo,
    output logic        enable_conv,
    output logic        enable_lag,
    output logic        enable_approx,
    output logic        enable_cancel,
    output logic        enable_out,
    output logic [63:0] double_out,
    output logic [31:0] iteration,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam logic [TMR_W-1:0] PC      = TMR_W'(PULSE_CYCLES);
    localparam logic [TMR_W-1:0] MW_CONV = TMR_W'(MIN_WAIT_CONV);
    localparam logic [TMR_W-1:0] MW_LAG  = TMR_W'(MIN_WAIT_LAG);
    localparam logic [TMR_W-1:0] MW_S3   = TMR_W'(MIN_WAIT_S3);
    localparam logic [TMR_W-1:0] TMO     = TMR_W'(TIMEOUT);

    seq_state_e       state_q;
    logic             mode_q;
    logic [TMR_W-1:0] pcnt_q;
    logic             en_conv_q;
    logic             en_lag_q;
    logic             en_approx_q;
    logic             en_cancel_q;
    logic             en_out_q;
    logic [63:0]      dout_q;
    logic [31:0]      iter_q;
    logic             err_tmo_q;
    logic             err_ovr_q;

    logic             frame_start;
    logic             pulse_done;
    logic             tmr_load;
    logic             tmr_run;
    logic [TMR_W-1:0] tmr_min;
    logic             min_done;
    logic             timed_out;
    logic             stage_ready;
    logic             stage_adv;
    logic             stage_tmo;

    assign frame_start = (sampling_cycle_counter == 13'd0);
    assign pulse_done  = (pcnt_q >= PC);
    assign tmr_load    = is_en_state(state_q) && pulse_done;
    assign tmr_run     = is_wait_state(state_q);

    // Per-stage minimum wait and ready selection; stage 3 follows the
    // mode latched at frame start, not the live mode input.
    always_comb begin
        tmr_min     = MW_CONV;
        stage_ready = 1'b0;
        unique case (state_q)
            ST_CONV_EN, ST_CONV_WAIT: begin
                tmr_min     = MW_CONV;
                stage_ready = ready_conv;
            end
            ST_LAG_EN, ST_LAG_WAIT: begin
                tmr_min     = MW_LAG;
                stage_ready = ready_lag;
            end
            ST_S3_EN, ST_S3_WAIT: begin
                tmr_min     = MW_S3;
                stage_ready = mode_q ? ready_approx : ready_cancel;
            end
            default: begin
                tmr_min     = MW_CONV;
                stage_ready = 1'b0;
            end
        endcase
    end

    assign stage_adv = tmr_run && min_done && stage_ready;
    assign stage_tmo = tmr_run && timed_out && !stage_ready;

    stage_wait_timer u_timer (
        .clk_i       (clk_operation),
        .rst_i       (rst),
        .load_i      (tmr_load),
        .run_i       (tmr_run),
        .min_wait_i  (tmr_min),
        .timeout_i   (TMO),
        .min_done_o  (min_done),
        .timed_out_o (timed_out)
    );

    // Frame FSM with registered enables, result and error flags.
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            pcnt_q      <= '0;
            en_conv_q   <= 1'b0;
            en_lag_q    <= 1'b0;
            en_approx_q <= 1'b0;
            en_cancel_q <= 1'b0;
            en_out_q    <= 1'b0;
            dout_q      <= '0;
            iter_q      <= '0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            if (frame_start && (state_q != ST_IDLE)) begin
                err_ovr_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q   <= ST_CONV_EN;
                        mode_q    <= enable_para_approx;
                        en_conv_q <= 1'b1;
                        pcnt_q    <= TMR_W'(1);
                    end
                end
                ST_CONV_EN: begin
                    if (pulse_done) begin
                        state_q   <= ST_CONV_WAIT;
                        en_conv_q <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q + TMR_W'(1);
                    end
                end
                ST_CONV_WAIT: begin
                    if (stage_adv) begin
                        state_q  <= ST_LAG_EN;
                        en_lag_q <= 1'b1;
                        pcnt_q   <= TMR_W'(1);
                    end else if (stage_tmo) begin
                        state_q   <= ST_IDLE;
                        err_tmo_q <= 1'b1;
                    end
                end
                ST_LAG_EN: begin
                    if (pulse_done) begin
                        state_q  <= ST_LAG_WAIT;
                        en_lag_q <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q + TMR_W'(1);
                    end
                end
                ST_LAG_WAIT: begin
                    if (stage_adv) begin
                        state_q     <= ST_S3_EN;
                        en_approx_q <= mode_q;
                        en_cancel_q <= !mode_q;
                        pcnt_q      <= TMR_W'(1);
                    end else if (stage_tmo) begin
                        state_q   <= ST_IDLE;
                        err_tmo_q <= 1'b1;
                    end
                end
                ST_S3_EN: begin
                    if (pulse_done) begin
                        state_q     <= ST_S3_WAIT;
                        en_approx_q <= 1'b0;
                        en_cancel_q <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q + TMR_W'(1);
                    end
                end
                ST_S3_WAIT: begin
                    if (stage_adv) begin
                        state_q  <= ST_EMIT;
                        en_out_q <= 1'b1;
                        dout_q   <= mode_q ? e : signal_without_echo;
                        if (mode_q) begin
                            iter_q <= iter_q + 32'd1;
                        end
                    end else if (stage_tmo) begin
                        state_q   <= ST_IDLE;
                        err_tmo_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    state_q  <= ST_IDLE;
                    en_out_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign enable_conv   = en_conv_q;
    assign enable_lag    = en_lag_q;
    assign enable_approx = en_approx_q;
    assign enable_cancel = en_cancel_q;
    assign enable_out    = en_out_q;
    assign double_out    = dout_q;
    assign iteration     = iter_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_timeout   = err_tmo_q;
    assign err_overrun   = err_ovr_q;

endmodule
